// File: rtl/microwave_cook_ctrl_pkg.sv
// Shared definitions for the microwave cook controller: state codes, BCD limits
// and the state-code width.
package microwave_cook_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/microwave_cook_ctrl_decrement.sv
// Combinational MM:SS BCD minus-one-second with the borrow chain
// sec_ones -> sec_tens -> min_ones -> min_tens.
module bcd_mmss_decrement
  import microwave_cook_ctrl_pkg::*;
(
  input  logic [15:0] mmss,
  output logic [15:0] mmss_dec,
  output logic        is_one
);

  logic [3:0] mt, mo, st, so;
  logic       b0, b1, b2;

  assign mt = mmss[15:12];
  assign mo = mmss[11:8];
  assign st = mmss[7:4];
  assign so = mmss[3:0];

  // Each borrow propagates only when every lower digit is zero.
  assign b0 = (so == 4'd0);
  assign b1 = b0 && (st == 4'd0);
  assign b2 = b1 && (mo == 4'd0);

  always_comb begin
    mmss_dec[3:0]   = b0 ? BCD_MAX_ONES : so - 4'd1;
    mmss_dec[7:4]   = b0 ? ((st == 4'd0) ? BCD_MAX_TENS_SEC : st - 4'd1) : st;
    mmss_dec[11:8]  = b1 ? ((mo == 4'd0) ? BCD_MAX_ONES : mo - 4'd1) : mo;
    mmss_dec[15:12] = b2 ? mt - 4'd1 : mt;
  end

  assign is_one = (mmss == 16'h0001);

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle controller: keypad MM:SS entry, BCD countdown from a 1-second
// prescaler, door-interlocked magnetron enable and a timed done indication.
module microwave_cook_ctrl
  import microwave_cook_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int DONE_SECS     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [3:0]   key_digit,
  input  logic         start,
  input  logic         stop_clear,
  input  logic         door_open,
  output logic [15:0]  time_bcd,
  output logic         magnetron_on,
  output logic         done,
  output logic [2:0]   state
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = (DONE_SECS > 1) ? $clog2(DONE_SECS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_SECS - 1);

  state_t        st_q;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [DW-1:0] done_cnt;
  logic          tick;
  logic          key_ok;
  logic [15:0]   dec_val;
  logic          dec_is_one;

  // A tens digit above 5 saturates that field to x:59-style 5/9.
  function automatic logic [15:0] clamp_mmss(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[15:12] > BCD_MAX_TENS_SEC) begin
      r[15:12] = BCD_MAX_TENS_SEC;
      r[11:8]  = BCD_MAX_ONES;
    end
    if (t[7:4] > BCD_MAX_TENS_SEC) begin
      r[7:4] = BCD_MAX_TENS_SEC;
      r[3:0] = BCD_MAX_ONES;
    end
    return r;
  endfunction

  bcd_mmss_decrement u_dec (
    .mmss     (time_bcd),
    .mmss_dec (dec_val),
    .is_one   (dec_is_one)
  );

  assign tick      = (presc == PRE_LAST);
  assign presc_nxt = tick ? '0 : presc + PW'(1);
  assign key_ok    = key_valid && (key_digit <= BCD_MAX_ONES);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      time_bcd <= 16'h0000;
      presc    <= '0;
      done_cnt <= '0;
      done     <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (key_ok) begin
            time_bcd <= {12'h000, key_digit};
            st_q     <= ST_SET;
          end
        end
        ST_SET: begin
          if (stop_clear) begin
            time_bcd <= 16'h0000;
            st_q     <= ST_IDLE;
          end else if (start && !door_open && (time_bcd != 16'h0000)) begin
            time_bcd <= clamp_mmss(time_bcd);
            presc    <= '0;
            st_q     <= ST_COOK;
          end else if (key_ok) begin
            time_bcd <= {time_bcd[11:0], key_digit};
          end
        end
        ST_COOK: begin
          // The count for this cycle always lands, even when pausing.
          presc <= presc_nxt;
          if (tick) time_bcd <= dec_val;
          if (tick && dec_is_one) begin
            st_q     <= ST_DONE;
            done     <= 1'b1;
            done_cnt <= '0;
          end else if (stop_clear || door_open) begin
            st_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (stop_clear) begin
            time_bcd <= 16'h0000;
            presc    <= '0;
            st_q     <= ST_IDLE;
          end else if (start && !door_open) begin
            st_q <= ST_COOK;
          end
        end
        ST_DONE: begin
          if (stop_clear || key_ok) begin
            st_q     <= ST_IDLE;
            done     <= 1'b0;
            presc    <= '0;
            done_cnt <= '0;
          end else begin
            presc <= presc_nxt;
            if (tick) begin
              if (done_cnt == DONE_LAST) begin
                st_q     <= ST_IDLE;
                done     <= 1'b0;
                done_cnt <= '0;
              end else begin
                done_cnt <= done_cnt + DW'(1);
              end
            end
          end
        end
        default: begin
          st_q     <= ST_IDLE;
          done     <= 1'b0;
          presc    <= '0;
          done_cnt <= '0;
        end
      endcase
    end
  end

  // Interlock path is deliberately combinational so the door cuts power at once.
  assign magnetron_on = (st_q == ST_COOK) && !door_open;
  assign state        = st_q;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Bench for microwave_cook_ctrl with TICKS_PER_SEC=4, DONE_SECS=2: a vector
// table plus hand-written multi-cycle sequences, checked through a queue.
module tb_microwave_cook_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic        clk = 1'b0;
  logic        reset, key_valid, start, stop_clear, door_open;
  logic [3:0]  key_digit;
  logic [15:0] time_bcd;
  logic        magnetron_on, done;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_fail = 0;
  int step   = 0;

  typedef struct packed {
    logic        rst;
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        sc;
    logic        door;
    logic [2:0]  es;
    logic [15:0] et;
    logic        em;
    logic        ed;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  microwave_cook_ctrl #(.TICKS_PER_SEC(4), .DONE_SECS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop_clear   (stop_clear),
    .door_open    (door_open),
    .time_bcd     (time_bcd),
    .magnetron_on (magnetron_on),
    .done         (done),
    .state        (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rst, input logic kv, input logic [3:0] kd,
                              input logic st, input logic sc, input logic door,
                              input logic [2:0] es, input logic [15:0] et,
                              input logic em, input logic ed);
    vec_t v;
    v.rst = rst; v.kv = kv; v.kd = kd; v.st = st; v.sc = sc; v.door = door;
    v.es = es; v.et = et; v.em = em; v.ed = ed;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d %s: got %h expected %h", tag, step, what, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    reset = v.rst; key_valid = v.kv; key_digit = v.kd;
    start = v.st; stop_clear = v.sc; door_open = v.door;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step++;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s #%0d scoreboard empty", tag, step);
    end else begin
      e = sb.pop_front();
      cmp(tag, "state", {13'd0, state}, {13'd0, e.es});
      cmp(tag, "time_bcd", time_bcd, e.et);
      cmp(tag, "magnetron_on", {15'd0, magnetron_on}, {15'd0, e.em});
      cmp(tag, "done", {15'd0, done}, {15'd0, e.ed});
    end
  endtask

  task automatic t_key(input logic [3:0] d, input logic [2:0] es, input logic [15:0] et,
                       input string tag);
    apply(mk(0, 1, d, 0, 0, 0, es, et, 0, 0), tag);
  endtask

  task automatic t_idle(input int n, input logic [2:0] es, input logic [15:0] et,
                        input logic em, input logic ed, input string tag);
    for (int i = 0; i < n; i++) apply(mk(0, 0, 4'd0, 0, 0, 0, es, et, em, ed), tag);
  endtask

  task automatic t_start(input logic [2:0] es, input logic [15:0] et, input logic em,
                         input string tag);
    apply(mk(0, 0, 4'd0, 1, 0, 0, es, et, em, 0), tag);
  endtask

  task automatic t_stop(input logic [2:0] es, input logic [15:0] et, input string tag);
    apply(mk(0, 0, 4'd0, 0, 1, 0, es, et, 0, 0), tag);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop_clear = 1'b0; door_open = 1'b0;

    // Reset, entry 1:30 countdown, clamp cases, ignored keys and starts.
    tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(1, 1, 4'd5, 1, 0, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd1, 0, 0, 0, S_SET,   16'h0001, 0, 0));
    tbl.push_back(mk(0, 1, 4'd3, 0, 0, 0, S_SET,   16'h0013, 0, 0));
    tbl.push_back(mk(0, 1, 4'd0, 0, 0, 0, S_SET,   16'h0130, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_COOK,  16'h0130, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0130, 1, 0));
    tbl.push_back(mk(0, 1, 4'd7, 0, 0, 0, S_COOK,  16'h0130, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0130, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0129, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0129, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0129, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0129, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0128, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_PAUSE, 16'h0128, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd1, 0, 0, 0, S_SET,   16'h0001, 0, 0));
    tbl.push_back(mk(0, 1, 4'd7, 0, 0, 0, S_SET,   16'h0017, 0, 0));
    tbl.push_back(mk(0, 1, 4'd5, 0, 0, 0, S_SET,   16'h0175, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_COOK,  16'h0159, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_PAUSE, 16'h0159, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd9, 0, 0, 0, S_SET,   16'h0009, 0, 0));
    tbl.push_back(mk(0, 1, 4'd9, 0, 0, 0, S_SET,   16'h0099, 0, 0));
    tbl.push_back(mk(0, 1, 4'd9, 0, 0, 0, S_SET,   16'h0999, 0, 0));
    tbl.push_back(mk(0, 1, 4'd9, 0, 0, 0, S_SET,   16'h9999, 0, 0));
    tbl.push_back(mk(0, 1, 4'd9, 0, 0, 0, S_SET,   16'h9999, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_COOK,  16'h5959, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_PAUSE, 16'h5959, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'hC, 0, 0, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd2, 0, 0, 0, S_SET,   16'h0002, 0, 0));
    tbl.push_back(mk(0, 1, 4'hC, 0, 0, 0, S_SET,   16'h0002, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd5, 0, 0, 0, S_SET,   16'h0005, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 1, S_SET,   16'h0005, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd0, 0, 0, 0, S_SET,   16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_SET,   16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd3, 0, 0, 0, S_SET,   16'h0003, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_COOK,  16'h0003, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 1, 0, S_PAUSE, 16'h0003, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 1, 0, S_IDLE,  16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd0, 0, 0, 0, S_SET,   16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 4'd1, 0, 0, 0, S_SET,   16'h0001, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 0, S_COOK,  16'h0001, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0001, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0001, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_COOK,  16'h0001, 1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, S_DONE,  16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 4'd7, 0, 0, 0, S_IDLE,  16'h0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table");

    // Full countdown into DONE, done held for DONE_SECS seconds, start ignored.
    t_key(4'd0, S_SET, 16'h0000, "done_seq");
    t_key(4'd2, S_SET, 16'h0002, "done_seq");
    t_start(S_COOK, 16'h0002, 1, "done_seq");
    t_idle(3, S_COOK, 16'h0002, 1, 0, "done_seq");
    t_idle(1, S_COOK, 16'h0001, 1, 0, "done_seq");
    t_idle(3, S_COOK, 16'h0001, 1, 0, "done_seq");
    t_idle(1, S_DONE, 16'h0000, 0, 1, "done_seq");
    t_idle(1, S_DONE, 16'h0000, 0, 1, "done_seq");
    apply(mk(0, 0, 4'd0, 1, 0, 0, S_DONE, 16'h0000, 0, 1), "done_start");
    t_idle(5, S_DONE, 16'h0000, 0, 1, "done_seq");
    t_idle(1, S_IDLE, 16'h0000, 0, 0, "done_exit");

    // stop_clear aborts DONE immediately.
    t_key(4'd1, S_SET, 16'h0001, "done_stop");
    t_start(S_COOK, 16'h0001, 1, "done_stop");
    t_idle(3, S_COOK, 16'h0001, 1, 0, "done_stop");
    t_idle(1, S_DONE, 16'h0000, 0, 1, "done_stop");
    t_stop(S_IDLE, 16'h0000, "done_stop");

    // Door interlock: magnetron drops combinationally, prescaler resumes.
    t_key(4'd1, S_SET, 16'h0001, "door");
    t_key(4'd0, S_SET, 16'h0010, "door");
    t_start(S_COOK, 16'h0010, 1, "door");
    t_idle(2, S_COOK, 16'h0010, 1, 0, "door");
    door_open = 1'b1;
    #1;
    cmp("door_same_cycle", "magnetron_on", {15'd0, magnetron_on}, 16'd0);
    cmp("door_same_cycle", "state", {13'd0, state}, {13'd0, S_COOK});
    apply(mk(0, 0, 4'd0, 0, 0, 1, S_PAUSE, 16'h0010, 0, 0), "door_pause");
    apply(mk(0, 0, 4'd0, 0, 0, 1, S_PAUSE, 16'h0010, 0, 0), "door_hold");
    apply(mk(0, 0, 4'd0, 1, 0, 1, S_PAUSE, 16'h0010, 0, 0), "door_start_open");
    t_start(S_COOK, 16'h0010, 1, "door_resume");
    t_idle(1, S_COOK, 16'h0009, 1, 0, "door_resume");
    t_stop(S_PAUSE, 16'h0009, "door");
    t_stop(S_IDLE, 16'h0000, "door");

    // Reset mid-COOK.
    t_key(4'd4, S_SET, 16'h0004, "rst_mid");
    t_key(4'd2, S_SET, 16'h0042, "rst_mid");
    t_start(S_COOK, 16'h0042, 1, "rst_mid");
    t_idle(1, S_COOK, 16'h0042, 1, 0, "rst_mid");
    apply(mk(1, 0, 4'd0, 0, 0, 0, S_IDLE, 16'h0000, 0, 0), "rst_mid");

    // Borrow chains: 10:00 -> 9:59 and 1:00 -> 0:59.
    t_key(4'd1, S_SET, 16'h0001, "dec1000");
    t_key(4'd0, S_SET, 16'h0010, "dec1000");
    t_key(4'd0, S_SET, 16'h0100, "dec1000");
    t_key(4'd0, S_SET, 16'h1000, "dec1000");
    t_start(S_COOK, 16'h1000, 1, "dec1000");
    t_idle(3, S_COOK, 16'h1000, 1, 0, "dec1000");
    t_idle(1, S_COOK, 16'h0959, 1, 0, "dec1000");
    t_stop(S_PAUSE, 16'h0959, "dec1000");
    t_stop(S_IDLE, 16'h0000, "dec1000");
    t_key(4'd1, S_SET, 16'h0001, "dec0100");
    t_key(4'd0, S_SET, 16'h0010, "dec0100");
    t_key(4'd0, S_SET, 16'h0100, "dec0100");
    t_start(S_COOK, 16'h0100, 1, "dec0100");
    t_idle(3, S_COOK, 16'h0100, 1, 0, "dec0100");
    t_idle(1, S_COOK, 16'h0059, 1, 0, "dec0100");
    t_stop(S_PAUSE, 16'h0059, "dec0100");
    t_stop(S_IDLE, 16'h0000, "dec0100");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
